// File: rtl/uart_rx_unit.sv
// -----------------------------------------------------------------------------
// uart_rx_unit
//
// Serial-line receive front end for the debug core. The raw uart_rx pin is
// passed through a two-flop synchroniser, 8N1 frames are deserialised by a
// small FSM, and good bytes are buffered in a first-word-fall-through FIFO
// that the core drains with a valid/ready handshake. Framing errors, FIFO
// overflow and an end-of-transfer idle timeout are reported as one-cycle
// pulses.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, an even-parity bit is expected between the last data bit and
//   the stop bit, and the o_parity_error pulse output is added. When undefined
//   the receiver is 8N1 only and o_parity_error does not exist.
//
// Parameters:
//   CLKS_PER_BIT    clock cycles per UART bit (>= 8)
//   FIFO_DEPTH      receive FIFO slots (power of 2)
//   FIFO_ADDR_WIDTH log2(FIFO_DEPTH)
//   IDLE_BITS       idle bit periods after a good frame before o_idle_timeout
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst           synchronous reset, active-high
//   i_uart_rx       raw asynchronous serial input, idle-high
//   o_rx_data       byte at the FIFO head (meaningful while o_rx_valid)
//   o_rx_valid      FIFO not empty
//   i_rx_ready      consumer accepts the head byte this cycle
//   o_fifo_count    FIFO occupancy
//   o_frame_error   pulse: stop bit sampled low
//   o_overflow      pulse: completed byte dropped, FIFO full
//   o_parity_error  pulse: parity mismatch (UART_RX_PARITY_EN only)
//   o_idle_timeout  pulse: line idle IDLE_BITS bit periods after a good frame
// -----------------------------------------------------------------------------
module uart_rx_unit #(
    parameter int unsigned CLKS_PER_BIT    = 868,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned FIFO_ADDR_WIDTH = 2,
    parameter int unsigned IDLE_BITS       = 10
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_uart_rx,
    output logic [7:0]                 o_rx_data,
    output logic                       o_rx_valid,
    input  logic                       i_rx_ready,
    output logic [FIFO_ADDR_WIDTH:0]   o_fifo_count,
    output logic                       o_frame_error,
    output logic                       o_overflow,
`ifdef UART_RX_PARITY_EN
    output logic                       o_parity_error,
`endif
    output logic                       o_idle_timeout
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDLE_W = $clog2(IDLE_BITS + 1);

    localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]         CNT_MID   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDLE_W-1:0]        IDLE_LAST = IDLE_W'(IDLE_BITS - 1);
    localparam logic [FIFO_ADDR_WIDTH:0] FIFO_FULL = (FIFO_ADDR_WIDTH + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_rxs;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // ------------------------------------------------------------------
    // Receive FSM and idle timer
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_d;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_d;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_d;
    logic               r_idle_armed;
    logic               w_idle_armed_d;
    logic [IDLE_W-1:0]  r_idle_bits;
    logic [IDLE_W-1:0]  w_idle_bits_d;

    logic               w_push;
    logic               w_frame_err;
    logic               w_idle_fire;

`ifdef UART_RX_PARITY_EN
    logic               r_parity_bit;
    logic               w_parity_bit_d;
    logic               w_parity_err;
    logic               r_parity_error;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_idle_armed <= 1'b0;
            r_idle_bits  <= '0;
`ifdef UART_RX_PARITY_EN
            r_parity_bit <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_bit_idx    <= w_bit_idx_d;
            r_shift      <= w_shift_d;
            r_idle_armed <= w_idle_armed_d;
            r_idle_bits  <= w_idle_bits_d;
`ifdef UART_RX_PARITY_EN
            r_parity_bit <= w_parity_bit_d;
`endif
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_bit_idx_d    = r_bit_idx;
        w_shift_d      = r_shift;
        w_idle_armed_d = r_idle_armed;
        w_idle_bits_d  = r_idle_bits;
        w_push         = 1'b0;
        w_frame_err    = 1'b0;
        w_idle_fire    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parity_bit_d = r_parity_bit;
        w_parity_err   = 1'b0;
`endif

        case (r_state)
            StIdle: begin
                if (!w_rxs) begin
                    // Start edge: restart the idle count but stay armed.
                    w_state_d     = StStart;
                    w_cnt_d       = '0;
                    w_idle_bits_d = '0;
                end else if (r_idle_armed) begin
                    // The bit counter is otherwise unused in IDLE, so it
                    // doubles as the idle bit-period timer.
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_d = '0;
                        if (r_idle_bits == IDLE_LAST) begin
                            w_idle_fire    = 1'b1;
                            w_idle_armed_d = 1'b0;
                            w_idle_bits_d  = '0;
                        end else begin
                            w_idle_bits_d = r_idle_bits + 1'b1;
                        end
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end

            StStart: begin
                if (r_cnt == CNT_MID) begin
                    w_cnt_d = '0;
                    if (w_rxs) begin
                        // Line went back high before mid start bit: glitch.
                        w_state_d = StIdle;
                    end else begin
                        w_state_d   = StData;
                        w_bit_idx_d = '0;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end

            StData: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_d     = '0;
                    w_shift_d   = {w_rxs, r_shift[7:1]};
                    w_bit_idx_d = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_d = StParity;
`else
                        w_state_d = StStop;
`endif
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_d        = '0;
                    w_parity_bit_d = w_rxs;
                    w_state_d      = StStop;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
`endif

            StStop: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_d = '0;
                    if (w_rxs) begin
                        w_state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                        if (^{r_shift, r_parity_bit}) begin
                            w_parity_err   = 1'b1;
                            w_idle_armed_d = 1'b0;
                        end else
`endif
                        begin
                            w_push         = 1'b1;
                            w_idle_armed_d = 1'b1;
                            w_idle_bits_d  = '0;
                        end
                    end else begin
                        // Framing error wins over parity; wait out the low line.
                        w_frame_err    = 1'b1;
                        w_idle_armed_d = 1'b0;
                        w_state_d      = StBreak;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end

            StBreak: begin
                if (w_rxs) begin
                    w_state_d     = StIdle;
                    w_cnt_d       = '0;
                    w_idle_bits_d = '0;
                end
            end

            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [7:0]                 r_mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]   r_count;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_push_ok;
    logic                       w_overflow;

    assign w_full     = (r_count == FIFO_FULL);
    assign w_pop      = o_rx_valid & i_rx_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO is legal.
    assign w_push_ok  = w_push & (~w_full | w_pop);
    assign w_overflow = w_push & w_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status pulses
    // ------------------------------------------------------------------
    logic r_frame_error;
    logic r_overflow;
    logic r_idle_timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_error  <= 1'b0;
            r_overflow     <= 1'b0;
            r_idle_timeout <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_error <= 1'b0;
`endif
        end else begin
            r_frame_error  <= w_frame_err;
            r_overflow     <= w_overflow;
            r_idle_timeout <= w_idle_fire;
`ifdef UART_RX_PARITY_EN
            r_parity_error <= w_parity_err;
`endif
        end
    end

    assign o_rx_data      = r_mem[r_rd_ptr];
    assign o_rx_valid     = (r_count != '0);
    assign o_fifo_count   = r_count;
    assign o_frame_error  = r_frame_error;
    assign o_overflow     = r_overflow;
    assign o_idle_timeout = r_idle_timeout;
`ifdef UART_RX_PARITY_EN
    assign o_parity_error = r_parity_error;
`endif

endmodule

// File: tb/tb_uart_rx_unit.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_unit
//
// Scoreboard bench for uart_rx_unit with CLKS_PER_BIT=16. Stimulus pushes the
// bytes it expects to be delivered into exp_q; the monitor pops and compares
// on every accepted handshake and also logs error/timeout pulses and their
// times. Build with +define+UART_RX_PARITY_EN to exercise the parity variant.
// -----------------------------------------------------------------------------
module tb_uart_rx_unit;

    localparam int CPB    = 16;
    localparam int PERIOD = 10;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Edges counted from the edge that launches the start bit: 2 sync flops
    // plus the IDLE detect put START at edge 3, mid start-bit sample at 3+8,
    // then every further bit 16 edges later; stop is 9 (10 with parity) on.
    localparam int STOP_EDGE = 11 + CPB * (9 + PB);
    // A registered pulse made at edge k is seen at the following negedge.
    localparam int STOP_SEEN = STOP_EDGE * PERIOD + PERIOD / 2;
    localparam int IDLE_SEEN = (STOP_EDGE + 10 * CPB) * PERIOD + PERIOD / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       frame_error;
    logic       overflow;
    logic       idle_timeout;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
    logic       par_flip = 1'b0;
`endif

    always #(PERIOD / 2) clk = ~clk;

    uart_rx_unit #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH      (4),
        .FIFO_ADDR_WIDTH (2),
        .IDLE_BITS       (10)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_uart_rx      (uart_rx),
        .o_rx_data      (rx_data),
        .o_rx_valid     (rx_valid),
        .i_rx_ready     (rx_ready),
        .o_fifo_count   (fifo_count),
        .o_frame_error  (frame_error),
        .o_overflow     (overflow),
`ifdef UART_RX_PARITY_EN
        .o_parity_error (parity_error),
`endif
        .o_idle_timeout (idle_timeout)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         n_ferr  = 0;
    int         n_ovf   = 0;
    int         n_idle  = 0;
    int         n_perr  = 0;
    time        rise_t  = 0;
    time        ferr_t  = 0;
    time        ovf_t   = 0;
    time        idle_t  = 0;
    logic       prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops and pulse logging, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (rx_valid && !prev_valid) rise_t = $time;
            prev_valid = rx_valid;
            if (frame_error) begin n_ferr++; ferr_t = $time; end
            if (overflow) begin n_ovf++; ovf_t = $time; end
            if (idle_timeout) begin n_idle++; idle_t = $time; end
`ifdef UART_RX_PARITY_EN
            if (parity_error) n_perr++;
`endif
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got 0x%0h, expected no byte", rx_data);
                end else begin
                    check("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Drives one frame; t0 is the time of the edge launching the start bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, output time t0);
        @(posedge clk);
        t0 = $time;
        #1 uart_rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 uart_rx = data[i];
        end
`ifdef UART_RX_PARITY_EN
        repeat (CPB) @(posedge clk);
        #1 uart_rx = (^data) ^ par_flip;
`endif
        repeat (CPB) @(posedge clk);
        #1 uart_rx = stop_bit;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: %0d bytes never delivered, expected 0", name, exp_q.size());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({name, "_count"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        time t0;
        time tx;
        int  base;
        uart_rx  = 1'b1;
        rst      = 1'b1;
        rx_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_pulses", 32'({frame_error, overflow, idle_timeout}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);

        // 1: single byte held in the FIFO
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, t0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("s1_valid", 32'(rx_valid), 32'd1);
        check("s1_data", 32'(rx_data), 32'hA5);
        check("s1_count", 32'(fifo_count), 32'd1);
        check("s1_rise_time", 32'(rise_t - t0), 32'(STOP_SEEN));
        check("s1_no_errors", 32'(n_ferr + n_ovf + n_perr), 32'd0);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        drain("s1_drain");

        // 2: five back-to-back bytes into a 4-deep FIFO
        @(posedge clk);
        #1 rx_ready = 1'b0;
        base = n_ovf;
        for (int b = 1; b <= 4; b++) exp_q.push_back(8'(b));
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, t0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("s2_count_full", 32'(fifo_count), 32'd4);
        check("s2_ovf_pulses", 32'(n_ovf - base), 32'd1);
        check("s2_ovf_time", 32'(ovf_t - t0), 32'(STOP_SEEN));
        check("s2_head", 32'(rx_data), 32'h01);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        drain("s2_drain");

        // 3: 5-cycle glitch, then a real byte
        base = n_ferr;
        @(posedge clk);
        #1 uart_rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("s3_glitch_count", 32'(fifo_count), 32'd0);
        check("s3_glitch_ferr", 32'(n_ferr - base), 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, t0);
        drain("s3_drain");

        // 4: framing error with a held-low line, then a good byte
        base = n_ferr;
        send_frame(8'h55, 1'b0, t0);
        tx = t0;
        repeat (40) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("s4_ferr_pulses", 32'(n_ferr - base), 32'd1);
        check("s4_ferr_time", 32'(ferr_t - tx), 32'(STOP_SEEN));
        check("s4_discard", 32'(fifo_count), 32'd0);
        exp_q.push_back(8'h66);
        send_frame(8'h66, 1'b1, t0);
        drain("s4_drain");
        check("s4_ferr_once", 32'(n_ferr - base), 32'd1);

        // 5: idle timeout after a good frame, then reset mid-frame
        repeat (200) @(posedge clk);
        #1 rx_ready = 1'b0;
        base = n_idle;
        exp_q.push_back(8'h10);
        send_frame(8'h10, 1'b1, t0);
        repeat (500) @(posedge clk);
        @(negedge clk);
        check("s5_idle_pulses", 32'(n_idle - base), 32'd1);
        check("s5_idle_time", 32'(idle_t - t0), 32'(IDLE_SEEN));
        check("s5_held_count", 32'(fifo_count), 32'd1);
        check("s5_held_data", 32'(rx_data), 32'h10);
        @(posedge clk);
        #1 uart_rx = 1'b0;
        repeat (5 * CPB) @(posedge clk);
        #1;
        rst     = 1'b1;
        uart_rx = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("s5_rst_valid", 32'(rx_valid), 32'd0);
        check("s5_rst_count", 32'(fifo_count), 32'd0);
        check("s5_rst_data", 32'(rx_data), 32'd0);
        check("s5_rst_pulses", 32'({frame_error, overflow, idle_timeout}), 32'd0);
        base = n_ferr + n_ovf + n_idle + n_perr;
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("s5_quiet_after_rst", 32'(n_ferr + n_ovf + n_idle + n_perr - base), 32'd0);
        check("s5_nothing_pushed", 32'(fifo_count), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 6: even parity good and bad
        @(posedge clk);
        #1 rx_ready = 1'b1;
        base = n_perr;
        par_flip = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, t0);
        drain("s6_good");
        check("s6_good_no_perr", 32'(n_perr - base), 32'd0);
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, t0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("s6_bad_perr", 32'(n_perr - base), 32'd1);
        check("s6_bad_count", 32'(fifo_count), 32'd0);
        par_flip = 1'b0;
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
